// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits are served combinationally; misses write back a dirty victim and then refill one word per cycle.
module dcache_ctrl #(
  parameter int unsigned INDEX_W        = 4,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_mask,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned NumLines = 2 ** INDEX_W;
  localparam int unsigned TagW     = 32 - 4 - INDEX_W;

  typedef enum logic [1:0] {StIdle, StWriteback, StRefill} state_e;

  state_e              state_q;
  logic [1:0]          cnt_q;
  logic [NumLines-1:0] valid_q;
  logic [NumLines-1:0] dirty_q;
  logic [TagW-1:0]     tag_q  [NumLines];
  logic [31:0]         data_q [NumLines][WORDS_PER_LINE];

  logic [1:0]         offset;
  logic [1:0]         lane;
  logic [INDEX_W-1:0] index;
  logic [TagW-1:0]    tag;
  logic               hit;
  logic               store_ok;
  logic [31:0]        word_sel;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        store_word;

  assign lane     = cpu_addr[1:0];
  assign offset   = cpu_addr[3:2];
  assign index    = cpu_addr[4+INDEX_W-1:4];
  assign tag      = cpu_addr[31:4+INDEX_W];
  assign hit      = cpu_req && valid_q[index] && (tag_q[index] == tag);
  assign word_sel = data_q[index][offset];
  assign byte_sel = word_sel[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? word_sel[31:16] : word_sel[15:0];
  assign store_ok = cpu_we && (cpu_mask == 3'b000 || cpu_mask == 3'b001 || cpu_mask == 3'b010);
  assign mem_mask = 3'b010;

  // Load extraction follows the data memory's byte/halfword extension rules.
  always_comb begin
    cpu_rdata = '0;
    if (state_q == StIdle && hit && !cpu_we) begin
      case (cpu_mask)
        3'b000:  cpu_rdata = {{24{byte_sel[7]}}, byte_sel};
        3'b001:  cpu_rdata = {{16{half_sel[15]}}, half_sel};
        3'b010:  cpu_rdata = word_sel;
        3'b100:  cpu_rdata = {24'h0, byte_sel};
        3'b101:  cpu_rdata = {16'h0, half_sel};
        default: cpu_rdata = '0;
      endcase
    end
  end

  always_comb begin
    store_word = word_sel;
    case (cpu_mask)
      3'b000: store_word[{lane, 3'b000} +: 8] = cpu_wdata[7:0];
      3'b001: begin
        if (lane[1]) store_word[31:16] = cpu_wdata[15:0];
        else         store_word[15:0]  = cpu_wdata[15:0];
      end
      3'b010:  store_word = cpu_wdata;
      default: store_word = word_sel;
    endcase
  end

  always_comb begin
    cpu_stall = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    case (state_q)
      StIdle: cpu_stall = cpu_req && !hit;
      StWriteback: begin
        cpu_stall = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = {tag_q[index], index, cnt_q, 2'b00};
        mem_wdata = data_q[index][cnt_q];
      end
      StRefill: begin
        cpu_stall = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = {tag, index, cnt_q, 2'b00};
      end
      default: cpu_stall = 1'b0;
    endcase
  end

  // The core holds its request stable while stalled, so index/tag stay valid across the miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cpu_req) begin
            if (hit) begin
              if (store_ok) begin
                data_q[index][offset] <= store_word;
                dirty_q[index]        <= 1'b1;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= (valid_q[index] && dirty_q[index]) ? StWriteback : StRefill;
            end
          end
        end
        StWriteback: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cnt_q   <= '0;
            state_q <= StRefill;
          end
        end
        StRefill: begin
          data_q[index][cnt_q] <= mem_rdata;
          cnt_q                <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cnt_q          <= '0;
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
            tag_q[index]   <= tag;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a word-addressed backing memory (word i = i+1 at start).
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_mask;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_mask;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];
  logic        mem_init;
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];
  logic [31:0] wd_log[$];

  int vectors     = 0;
  int miscompares = 0;

  dcache_ctrl #(.INDEX_W(4), .WORDS_PER_LINE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_mask  (cpu_mask),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mask  (mem_mask),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'(i + 1);
    end else if (mem_wr_en) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
    if (mem_rd_en) rd_log.push_back(mem_addr);
    if (mem_wr_en) begin
      wr_log.push_back(mem_addr);
      wd_log.push_back(mem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    wd_log.delete();
  endtask

  // Issues one request at posedge+1, counts stall cycles, returns data seen on the first
  // non-stalled cycle, and ends at posedge+1 with the request dropped.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] mask, output int stalls, output logic [31:0] rdata);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_mask  = mask;
    stalls    = 0;
    @(negedge clk);
    while (cpu_stall === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    rdata = cpu_rdata;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    mem_init = 1'b1;
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    cpu_mask = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    vectors++; if (cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
    vectors++; if ({mem_wr_en, mem_rd_en} !== 2'b00) begin miscompares++; $display("FAIL reset_strobes: got %b want 00", {mem_wr_en, mem_rd_en}); end
    vectors++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata); end
    vectors++; if (mem_mask !== 3'b010) begin miscompares++; $display("FAIL mem_mask: got %b want 010", mem_mask); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_load();
    int stalls; logic [31:0] rd;
    clear_logs();
    do_req(1'b0, 32'h10, 32'h0, 3'b010, stalls, rd);
    vectors++; if (stalls !== 5) begin miscompares++; $display("FAIL cold_stalls: got %0d want 5", stalls); end
    vectors++; if (rd !== 32'h5) begin miscompares++; $display("FAIL cold_rdata: got %h want 00000005", rd); end
    vectors++; if (rd_log.size() != 4) begin miscompares++; $display("FAIL cold_rd_count: got %0d want 4", rd_log.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= rd_log.size() || rd_log[i] !== 32'h10 + 32'(4 * i)) begin
        miscompares++;
        $display("FAIL cold_rd_addr[%0d]: got %h want %h", i, (i < rd_log.size()) ? rd_log[i] : 32'hx, 32'h10 + 32'(4 * i));
      end
    end
    vectors++; if (wr_log.size() != 0) begin miscompares++; $display("FAIL cold_wr_count: got %0d want 0", wr_log.size()); end
  endtask

  task automatic test_hit_subword();
    int stalls; logic [31:0] rd;
    clear_logs();
    do_req(1'b0, 32'h14, 32'h0, 3'b010, stalls, rd);
    vectors++; if (stalls !== 0 || rd !== 32'h6) begin miscompares++; $display("FAIL hit_lw: got stalls %0d data %h want 0 00000006", stalls, rd); end
    do_req(1'b0, 32'h15, 32'h0, 3'b100, stalls, rd);
    vectors++; if (stalls !== 0 || rd !== 32'h0) begin miscompares++; $display("FAIL hit_lbu: got stalls %0d data %h want 0 00000000", stalls, rd); end
    do_req(1'b1, 32'h14, 32'hFF, 3'b000, stalls, rd);
    vectors++; if (stalls !== 0) begin miscompares++; $display("FAIL hit_sb_stall: got %0d want 0", stalls); end
    do_req(1'b0, 32'h14, 32'h0, 3'b000, stalls, rd);
    vectors++; if (rd !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL hit_lb: got %h want ffffffff", rd); end
    do_req(1'b1, 32'h17, 32'h80, 3'b000, stalls, rd);
    do_req(1'b0, 32'h17, 32'h0, 3'b000, stalls, rd);
    vectors++; if (rd !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lane3_lb: got %h want ffffff80", rd); end
    do_req(1'b0, 32'h17, 32'h0, 3'b100, stalls, rd);
    vectors++; if (rd !== 32'h00000080) begin miscompares++; $display("FAIL lane3_lbu: got %h want 00000080", rd); end
    do_req(1'b0, 32'h14, 32'h0, 3'b011, stalls, rd);
    vectors++; if (stalls !== 0 || rd !== 32'h0) begin miscompares++; $display("FAIL bad_mask_load: got stalls %0d data %h want 0 00000000", stalls, rd); end
    do_req(1'b1, 32'h14, 32'h12345678, 3'b111, stalls, rd);
    vectors++; if (stalls !== 0) begin miscompares++; $display("FAIL bad_mask_store_stall: got %0d want 0", stalls); end
    do_req(1'b0, 32'h14, 32'h0, 3'b010, stalls, rd);
    vectors++; if (rd !== 32'h800000FF) begin miscompares++; $display("FAIL bad_mask_store_nowrite: got %h want 800000ff", rd); end
    @(negedge clk);
    vectors++; if (cpu_rdata !== 32'h0 || cpu_stall !== 1'b0) begin miscompares++; $display("FAIL idle_no_req: got data %h stall %b want 0 0", cpu_rdata, cpu_stall); end
    vectors++; if (rd_log.size() != 0 || wr_log.size() != 0) begin miscompares++; $display("FAIL hit_mem_traffic: got rd %0d wr %0d want 0 0", rd_log.size(), wr_log.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_dirty_evict();
    int stalls; logic [31:0] rd;
    logic [31:0] exp_wd [4];
    exp_wd = '{32'hDEADBEEF, 32'hA, 32'hB, 32'hC};
    do_req(1'b1, 32'h20, 32'hDEADBEEF, 3'b010, stalls, rd);
    vectors++; if (stalls !== 5) begin miscompares++; $display("FAIL alloc_store_stalls: got %0d want 5", stalls); end
    clear_logs();
    do_req(1'b0, 32'h120, 32'h0, 3'b010, stalls, rd);
    vectors++; if (stalls !== 9) begin miscompares++; $display("FAIL dirty_stalls: got %0d want 9", stalls); end
    vectors++; if (rd !== 32'h49) begin miscompares++; $display("FAIL dirty_rdata: got %h want 00000049", rd); end
    vectors++; if (wr_log.size() != 4 || rd_log.size() != 4) begin miscompares++; $display("FAIL dirty_counts: got wr %0d rd %0d want 4 4", wr_log.size(), rd_log.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= wr_log.size() || wr_log[i] !== 32'h20 + 32'(4 * i) || wd_log[i] !== exp_wd[i]) begin
        miscompares++;
        $display("FAIL wb_word[%0d]: got %h=%h want %h=%h", i, (i < wr_log.size()) ? wr_log[i] : 32'hx,
                 (i < wd_log.size()) ? wd_log[i] : 32'hx, 32'h20 + 32'(4 * i), exp_wd[i]);
      end
    end
    vectors++; if (rd_log.size() > 0 && rd_log[0] !== 32'h120) begin miscompares++; $display("FAIL dirty_refill_addr: got %h want 00000120", rd_log[0]); end
    vectors++; if (mem[8] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL mem_word8: got %h want deadbeef", mem[8]); end
  endtask

  task automatic test_clean_evict();
    int stalls; logic [31:0] rd;
    do_req(1'b0, 32'h40, 32'h0, 3'b010, stalls, rd);
    vectors++; if (stalls !== 5 || rd !== 32'h11) begin miscompares++; $display("FAIL clean_first: got stalls %0d data %h want 5 00000011", stalls, rd); end
    clear_logs();
    do_req(1'b0, 32'h140, 32'h0, 3'b010, stalls, rd);
    vectors++; if (stalls !== 5 || rd !== 32'h51) begin miscompares++; $display("FAIL clean_evict: got stalls %0d data %h want 5 00000051", stalls, rd); end
    vectors++; if (wr_log.size() != 0) begin miscompares++; $display("FAIL clean_no_wb: got %0d writes want 0", wr_log.size()); end
    @(negedge clk);
    vectors++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_rd_en !== 1'b0) begin miscompares++; $display("FAIL idle_mem_bus: got addr %h wdata %h rd %b want 0", mem_addr, mem_wdata, mem_rd_en); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_halfword_store();
    int stalls; logic [31:0] rd;
    do_req(1'b1, 32'h32, 32'h1234, 3'b001, stalls, rd);
    vectors++; if (stalls !== 5) begin miscompares++; $display("FAIL sh_alloc_stalls: got %0d want 5", stalls); end
    do_req(1'b0, 32'h30, 32'h0, 3'b010, stalls, rd);
    vectors++; if (stalls !== 0 || rd !== 32'h1234000D) begin miscompares++; $display("FAIL sh_merge: got stalls %0d data %h want 0 1234000d", stalls, rd); end
    do_req(1'b1, 32'h34, 32'hABCD8001, 3'b001, stalls, rd);
    do_req(1'b0, 32'h34, 32'h0, 3'b001, stalls, rd);
    vectors++; if (rd !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh_sign: got %h want ffff8001", rd); end
    do_req(1'b0, 32'h34, 32'h0, 3'b101, stalls, rd);
    vectors++; if (rd !== 32'h00008001) begin miscompares++; $display("FAIL lhu_zero: got %h want 00008001", rd); end
    do_req(1'b0, 32'h32, 32'h0, 3'b001, stalls, rd);
    vectors++; if (rd !== 32'h00001234) begin miscompares++; $display("FAIL lh_upper: got %h want 00001234", rd); end
    do_req(1'b0, 32'h130, 32'h0, 3'b010, stalls, rd);
    vectors++; if (stalls !== 9 || rd !== 32'h4D) begin miscompares++; $display("FAIL sh_evict: got stalls %0d data %h want 9 0000004d", stalls, rd); end
    vectors++; if (mem[12] !== 32'h1234000D) begin miscompares++; $display("FAIL mem_word12: got %h want 1234000d", mem[12]); end
    vectors++; if (mem[13] !== 32'h00008001) begin miscompares++; $display("FAIL mem_word13: got %h want 00008001", mem[13]); end
  endtask

  task automatic test_reset_mid_refill();
    int stalls; logic [31:0] rd;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h50;
    cpu_mask = 3'b010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'h58) begin miscompares++; $display("FAIL third_refill: got rd %b addr %h want 1 00000058", mem_rd_en, mem_addr); end
    reset   = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (cpu_stall !== 1'b0 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got stall %b rd %b wr %b want 0 0 0", cpu_stall, mem_rd_en, mem_wr_en); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
    do_req(1'b0, 32'h50, 32'h0, 3'b010, stalls, rd);
    vectors++; if (stalls !== 5 || rd !== 32'h15) begin miscompares++; $display("FAIL reissue: got stalls %0d data %h want 5 00000015", stalls, rd); end
    vectors++; if (rd_log.size() != 4 || rd_log[0] !== 32'h50 || rd_log[3] !== 32'h5C) begin miscompares++; $display("FAIL reissue_refill: got %0d reads want 4 from 00000050", rd_log.size()); end
    // The dirty line at 0x10 was discarded by reset: no writeback, original memory data.
    clear_logs();
    do_req(1'b0, 32'h14, 32'h0, 3'b010, stalls, rd);
    vectors++; if (stalls !== 5 || rd !== 32'h6 || wr_log.size() != 0) begin miscompares++; $display("FAIL reset_discard: got stalls %0d data %h writes %0d want 5 00000006 0", stalls, rd, wr_log.size()); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_hit_subword();
    test_dirty_evict();
    test_clean_evict();
    test_halfword_store();
    test_reset_mid_refill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
